// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
// Line width is shared with the caches so every side agrees on the burst size.
package mem_arbiter_pkg;

    localparam int LINE_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } arb_side_t;

    // On a tie the side that was not served last wins.
    function automatic arb_side_t other_side(input arb_side_t s);
        return (s == SIDE_I) ? SIDE_D : SIDE_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_request_latch.sv
// Holds the granted transaction (op, line-aligned address, write line) for
// the whole memory access, so the requester is free to drop its inputs.
module arb_request_latch #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = mem_arbiter_pkg::LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  load_write,
    input  logic [ADDR_WIDTH-1:0] load_address,
    input  logic [LINE_WIDTH-1:0] load_wdata,
    output logic                  op_write,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [LINE_WIDTH-1:0] wdata
);

    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
        ADDR_WIDTH'((LINE_WIDTH / 32'sd8) - 32'sd1);

    logic                  op_write_r;
    logic [ADDR_WIDTH-1:0] address_r;
    logic [LINE_WIDTH-1:0] wdata_r;

    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
        return a & ~OFFSET_MASK;
    endfunction

    // Capture the winner's request on the grant edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_write_r <= 1'b0;
            address_r  <= '0;
            wdata_r    <= '0;
        end else if (load) begin
            op_write_r <= load_write;
            address_r  <= line_align(load_address);
            wdata_r    <= load_wdata;
        end else begin
            op_write_r <= op_write_r;
            address_r  <= address_r;
            wdata_r    <= wdata_r;
        end
    end

    assign op_write = op_write_r;
    assign address  = address_r;
    assign wdata    = wdata_r;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising I-side and D-side line transactions onto
// one physical memory port; a granted transaction always runs to mem_resp.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = mem_arbiter_pkg::LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    import mem_arbiter_pkg::*;

    arb_state_t            state_r;
    arb_side_t             last_grant_r;
    arb_side_t             winner_s;
    logic                  req_i_s;
    logic                  req_d_s;
    logic                  grant_s;
    logic                  win_write_s;
    logic [ADDR_WIDTH-1:0] win_address_s;
    logic [LINE_WIDTH-1:0] win_wdata_s;
    logic                  op_write_s;
    logic                  busy_s;

    // Pick the winner for this IDLE cycle and mux its request fields.
    always_comb begin
        req_i_s       = i_read | i_write;
        req_d_s       = d_read | d_write;
        winner_s      = SIDE_I;
        win_write_s   = 1'b0;
        win_address_s = '0;
        win_wdata_s   = '0;
        if (req_i_s && req_d_s) begin
            winner_s = other_side(last_grant_r);
        end else if (req_d_s) begin
            winner_s = SIDE_D;
        end else begin
            winner_s = SIDE_I;
        end
        grant_s = (state_r == IDLE) && (req_i_s || req_d_s);
        if (winner_s == SIDE_D) begin
            win_write_s   = d_write;
            win_address_s = d_address;
            win_wdata_s   = d_wdata;
        end else begin
            win_write_s   = i_write;
            win_address_s = i_address;
            win_wdata_s   = i_wdata;
        end
    end

    arb_request_latch #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LINE_WIDTH(LINE_WIDTH)
    ) u_latch (
        .clk         (clk),
        .rst         (rst),
        .load        (grant_s),
        .load_write  (win_write_s),
        .load_address(win_address_s),
        .load_wdata  (win_wdata_s),
        .op_write    (op_write_s),
        .address     (mem_address),
        .wdata       (mem_wdata)
    );

    // Arbiter FSM; mem_resp outside a grant is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= SIDE_I;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        state_r <= (winner_s == SIDE_D) ? GRANT_D : GRANT_I;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT_I: begin
                    if (mem_resp) begin
                        state_r      <= IDLE;
                        last_grant_r <= SIDE_I;
                    end else begin
                        state_r <= GRANT_I;
                    end
                end
                GRANT_D: begin
                    if (mem_resp) begin
                        state_r      <= IDLE;
                        last_grant_r <= SIDE_D;
                    end else begin
                        state_r <= GRANT_D;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    last_grant_r <= SIDE_I;
                end
            endcase
        end
    end

    // Strobes drop in the resp cycle so they can never touch the next transaction.
    assign busy_s    = (state_r != IDLE);
    assign mem_read  = busy_s & ~op_write_s & ~mem_resp;
    assign mem_write = busy_s &  op_write_s & ~mem_resp;
    assign i_resp    = (state_r == GRANT_I) & mem_resp;
    assign d_resp    = (state_r == GRANT_D) & mem_resp;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: a behavioural arbitration model
// predicts each grant, a monitor checks strobes and responses against it.
module tb_mem_arbiter;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [255:0] wd;
    } txn_t;

    typedef struct {
        bit           side;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wd;
        int           gcyc;
    } exp_t;

    logic          clk;
    bit            rst = 1'b1;
    logic          i_read, i_write, d_read, d_write;
    logic [31:0]   i_address, d_address;
    logic [255:0]  i_wdata, d_wdata, i_rdata, d_rdata;
    logic          i_resp, d_resp, mem_read, mem_write;
    logic [31:0]   mem_address;
    logic [255:0]  mem_wdata;
    logic [255:0]  mem_rdata = '0;
    logic          mem_resp = 1'b0;

    bit            rd_v[2], wr_v[2], waiting[2], done[2];
    logic [31:0]   addr_v[2];
    logic [255:0]  wd_v[2];
    txn_t          txn_i_q[$], txn_d_q[$];
    exp_t          exp_q[$];
    bit            served_q[$];

    int            checks = 0, errors = 0, cyc = 0;
    bit            rst_req = 1'b1, spur_req = 1'b0, rdata_fix_en = 1'b0;
    int            rate = 100, drop_pct = 0, lat_fixed = 0;
    logic [255:0]  rdata_fix = '0, resp_line = '0;
    bit            mem_active = 1'b0;
    int            mem_cnt = 0;
    bit            m_busy = 1'b0, m_cur = 1'b0, m_last = 1'b0;
    bit            prev_strobe = 1'b0;
    txn_t          drv_t;
    exp_t          mon_e;

    assign i_read = rd_v[0];  assign i_write = wr_v[0];
    assign d_read = rd_v[1];  assign d_write = wr_v[1];
    assign i_address = addr_v[0];  assign d_address = addr_v[1];
    assign i_wdata = wd_v[0];  assign d_wdata = wd_v[1];

    mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int qsize(input int s);
        return (s == 0) ? txn_i_q.size() : txn_d_q.size();
    endfunction

    function automatic txn_t qpop(input int s);
        return (s == 0) ? txn_i_q.pop_front() : txn_d_q.pop_front();
    endfunction

    function automatic bit idle_now();
        return txn_i_q.size() == 0 && txn_d_q.size() == 0 && !waiting[0] && !waiting[1]
               && !m_busy && exp_q.size() == 0;
    endfunction

    task automatic push_txn(input int s, input bit wr, input logic [31:0] a, input logic [255:0] wd);
        txn_t t;
        t.wr = wr; t.addr = a; t.wd = wd;
        if (s == 0) txn_i_q.push_back(t);
        else        txn_d_q.push_back(t);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!idle_now() && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        chk(name, idle_now(), 1'b1);
    endtask

    // Illegal input: read and write together on one side.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(i_read && i_write) && !(d_read && d_write))
                else $error("illegal read+write request on one side");
        end
    end

    // Reference model: a free port serves the sole requester, or on a tie the side not served last.
    always @(posedge clk) begin
        bit ri, rq, win;
        exp_t e;
        cyc = cyc + 1;
        if (rst) begin
            m_busy = 1'b0; m_last = 1'b0;
            exp_q.delete();
        end else if (m_busy) begin
            if (mem_resp) begin
                m_busy = 1'b0;
                m_last = m_cur;
            end
        end else begin
            ri = i_read | i_write;
            rq = d_read | d_write;
            if (ri || rq) begin
                win     = (ri && rq) ? !m_last : rq;
                e.side  = win;
                e.wr    = win ? d_write : i_write;
                e.addr  = win ? d_address : i_address;
                e.addr  = e.addr - (e.addr % 32);
                e.wd    = win ? d_wdata : i_wdata;
                e.gcyc  = cyc;
                exp_q.push_back(e);
                m_busy  = 1'b1;
                m_cur   = win;
            end
        end
    end

    // Memory model and requesters, all driven on the falling edge.
    always @(negedge clk) begin
        rst = rst_req;
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                rd_v[s] = 1'b0; wr_v[s] = 1'b0; waiting[s] = 1'b0; done[s] = 1'b0;
            end
            mem_resp = 1'b0; mem_active = 1'b0; mem_cnt = 0;
        end else begin
            if (mem_resp) begin
                mem_resp = 1'b0; mem_active = 1'b0;
            end else if (mem_active) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    resp_line = rdata_fix_en ? rdata_fix : rand_line();
                    mem_rdata = resp_line;
                    mem_resp  = 1'b1;
                end
            end else if (mem_read || mem_write) begin
                mem_active = 1'b1;
                mem_cnt = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 6);
            end else if (spur_req) begin
                spur_req = 1'b0;
                resp_line = rand_line();
                mem_rdata = resp_line;
                mem_resp = 1'b1;
            end
            for (int s = 0; s < 2; s++) begin
                if (done[s]) begin
                    done[s] = 1'b0; waiting[s] = 1'b0; rd_v[s] = 1'b0; wr_v[s] = 1'b0;
                end else if (waiting[s]) begin
                    if (m_busy && m_cur == s[0] && $urandom_range(0, 99) < drop_pct) begin
                        rd_v[s] = 1'b0; wr_v[s] = 1'b0;
                    end
                end else if (qsize(s) > 0 && $urandom_range(0, 99) < rate) begin
                    drv_t = qpop(s);
                    rd_v[s] = !drv_t.wr; wr_v[s] = drv_t.wr;
                    addr_v[s] = drv_t.addr; wd_v[s] = drv_t.wd;
                    waiting[s] = 1'b1;
                end
            end
        end
    end

    // Monitor: strobes and responses against the scoreboard queue.
    always @(negedge clk) begin
        bit strobe;
        #1;
        if (rst) begin
            prev_strobe = 1'b0;
        end else begin
            strobe = mem_read | mem_write;
            if (strobe && !prev_strobe) begin
                chk("strobe_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q[0];
                    chk("strobe_latency", cyc, mon_e.gcyc);
                    chk("mem_write", mem_write, mon_e.wr);
                    chk("mem_read", mem_read, !mon_e.wr);
                    chk("mem_address", mem_address, mon_e.addr);
                    chk("mem_wdata", mem_wdata, mon_e.wd);
                end
            end else if (strobe && exp_q.size() > 0) begin
                chk("hold_address", mem_address, exp_q[0].addr);
                chk("hold_write", mem_write, exp_q[0].wr);
                chk("hold_wdata", mem_wdata, exp_q[0].wd);
            end
            if (i_resp || d_resp) begin
                chk("resp_one_side", i_resp && d_resp, 1'b0);
                chk("strobe_in_resp", strobe, 1'b0);
                chk("resp_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("resp_side", d_resp, mon_e.side);
                    chk("i_rdata", i_rdata, resp_line);
                    chk("d_rdata", d_rdata, resp_line);
                    done[mon_e.side] = 1'b1;
                    served_q.push_back(mon_e.side);
                end
            end
            prev_strobe = strobe;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_i_resp", i_resp, 1'b0);
        chk("rst_d_resp", d_resp, 1'b0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 256'h0);
        rst_req = 1'b0;
        @(posedge clk); #2;

        // Single I read with fixed latency and line.
        lat_fixed = 5; rdata_fix_en = 1'b1; rdata_fix = {32{8'hAA}};
        push_txn(0, 1'b0, 32'h0000_0060, rand_line());
        wait_idle("i_read_done", 200);

        // mem_resp with nothing granted must be ignored.
        spur_req = 1'b1;
        @(negedge clk); #2;
        chk("spur_i_resp", i_resp, 1'b0);
        chk("spur_d_resp", d_resp, 1'b0);
        @(posedge clk); #2;

        // Single D writeback with an unaligned address.
        rdata_fix_en = 1'b0; lat_fixed = 3;
        push_txn(1, 1'b1, 32'h0000_1234, {32{8'h55}});
        wait_idle("d_write_done", 200);

        // Sustained contention from reset: D first, then strict alternation.
        rst_req = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_req = 1'b0;
        served_q.delete(); lat_fixed = 0;
        for (int k = 0; k < 3; k++) begin
            push_txn(0, 1'b0, $urandom, rand_line());
            push_txn(1, 1'b0, $urandom, rand_line());
        end
        wait_idle("contention_done", 600);
        chk("contention_count", served_q.size(), 6);
        for (int k = 0; k < served_q.size(); k++)
            chk("contention_order", served_q[k], (k % 2 == 0) ? 1'b1 : 1'b0);

        // Granted I drops its request mid-wait; resp still arrives.
        served_q.delete(); drop_pct = 100; lat_fixed = 5;
        push_txn(0, 1'b0, $urandom, rand_line());
        wait_idle("drop_done", 200);
        chk("drop_served_i", served_q.size() == 1 && served_q[0] == 1'b0, 1'b1);
        drop_pct = 0;

        // Reset in the middle of a D read.
        lat_fixed = 20;
        push_txn(1, 1'b0, $urandom, rand_line());
        for (int k = 0; k < 20 && !m_busy; k++) begin
            @(posedge clk); #2;
        end
        chk("rst_mid_granted", m_busy, 1'b1);
        repeat (3) @(posedge clk);
        #2 rst_req = 1'b1;
        @(posedge clk); #2;
        chk("rst_mid_mem_read", mem_read, 1'b0);
        chk("rst_mid_mem_write", mem_write, 1'b0);
        chk("rst_mid_d_resp", d_resp, 1'b0);
        rst_req = 1'b0;
        served_q.delete(); lat_fixed = 0;
        push_txn(0, 1'b0, $urandom, rand_line());
        push_txn(1, 1'b0, $urandom, rand_line());
        wait_idle("post_rst_done", 200);
        chk("post_rst_count", served_q.size(), 2);
        if (served_q.size() == 2) begin
            chk("post_rst_first_d", served_q[0], 1'b1);
            chk("post_rst_second_i", served_q[1], 1'b0);
        end

        // Random traffic on both sides.
        rate = 40; drop_pct = 15;
        for (int k = 0; k < 60; k++) begin
            push_txn(0, $urandom_range(0, 4) == 0, $urandom, rand_line());
            push_txn(1, $urandom_range(0, 1) == 0, $urandom, rand_line());
        end
        wait_idle("random_done", 20000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
